gpio_apb_arbiter: RTL and testbench
===================================

// Module: gpio_apb_arbiter
// PURPOSE
//  Shares the single APB slave port of the GPIO peripheral among NREQ requesters
//  (e.g. core load/store unit, DMA, debug module) by round-robin arbitration.
//  Sequences each granted request as a compliant APB SETUP/ACCESS transfer.
//  Returns read data, error and a one-cycle completion strobe to the winner.
//  Sits between the requester-side bus fabric and the GPIO APB slave.
// PARAMETERS
//  NREQ        2   number of requesters (2..8)
//  PADDR_SIZE  4   APB address width, matches GPIO slave
//  DATA_W      32  APB data width (multiple of 8)
//  TIMEOUT     16  ACCESS-phase cycle limit, used only when GPIO_ARB_TIMEOUT_EN is defined
// PORTS
//  pclk         in   1                 clock
//  prstn        in   1                 asynchronous active-low reset
//  req_i        in   NREQ              request, held until matching done_o[i]
//  req_addr_i   in   NREQ*PADDR_SIZE   per-requester address, slice i = [i*PADDR_SIZE +: PADDR_SIZE]
//  req_write_i  in   NREQ              1=write 0=read
//  req_wdata_i  in   NREQ*DATA_W       per-requester write data
//  req_strb_i   in   NREQ*DATA_W/8     per-requester byte strobes
//  done_o       out  NREQ              one-hot completion strobe, 1 cycle
//  rsp_rdata_o  out  DATA_W            read data, valid only while done_o!=0
//  rsp_err_o    out  1                 transfer error, valid only while done_o!=0
//  psel_o penable_o pwrite_o  out  1   APB master controls
//  paddr_o      out  PADDR_SIZE        APB address
//  pwdata_o     out  DATA_W            APB write data
//  pstrb_o      out  DATA_W/8          APB byte strobes
//  prdata_i     in   DATA_W            APB read data
//  pready_i pslverr_i  in  1           APB slave response
// BEHAVIOUR
//  - Reset: psel_o=penable_o=pwrite_o=0, paddr_o/pwdata_o/pstrb_o=0, done_o=0, FSM=IDLE, rr pointer=0.
//  - Reset mid-transfer aborts the transfer; no done_o is issued; requester re-requests.
//  - FSM:
//    IDLE   : if |req_i, pick winner, register its addr/write/wdata/strb onto APB outputs,
//             go to SETUP; else stay.
//    SETUP  : psel_o=1, penable_o=0; unconditionally go to ACCESS.
//    ACCESS : psel_o=1, penable_o=1, outputs stable.
//             If pready_i=1: done_o[winner]=1 combinationally this cycle,
//             rsp_rdata_o=prdata_i, rsp_err_o=pslverr_i; go to IDLE.
//  - Arbitration: round-robin starting at index (last_winner+1) mod NREQ, wrapping; the pointer
//    updates only on completion. The first grant after reset favours requester 0.
//  - Requester may drop or change req at the edge after done_o; IDLE re-samples fresh requests.
//  - Mandatory IDLE cycle between transfers: min 3 cycles per transfer with pready_i tied 1.
//    Latency: req seen in IDLE at cycle k -> done_o in cycle k+2.
//  - Changing requester inputs other than req_i during a transfer has no effect (latched in IDLE).
//  - Deasserting req before done_o is illegal; the transfer still completes and done_o still pulses.
//  - Read data is not registered; the requester must capture it on done_o.
//  - Write transfers return rsp_rdata_o as don't-care; rsp_err_o is valid.
// CONFIGURATION
//  GPIO_ARB_TIMEOUT_EN defined:
//    - An ACCESS cycle counter clears on entry to ACCESS.
//    - If pready_i stays 0 for TIMEOUT cycles, the transfer terminates:
//      done_o[winner]=1, rsp_err_o=1, FSM -> IDLE, rr pointer advances.
//    - A subsequent late pready_i is ignored.
//  GPIO_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready_i indefinitely.
// TESTING
//  1. req0 write addr=1 data=0xFF strb=0xF, pready=1 -> SETUP@k+1, ACCESS@k+2,
//     done_o=01@k+2, pwdata_o=0xFF, rsp_err_o=0.
//  2. req0,req1 both held after reset, each re-requesting -> grants alternate 0,1,0,1; done every 3 cycles.
//  3. req1 read addr=3, prdata_i=0xA5A5_0001 in ACCESS -> done_o=10, rsp_rdata_o=0xA5A5_0001.
//  4. pready_i=0 for 5 ACCESS cycles then 1 -> APB signals stable throughout; single done_o pulse.
//  5. prstn low during ACCESS -> all outputs 0 next cycle, no done_o; after release requester 0 wins first.
//  6. GPIO_ARB_TIMEOUT_EN, TIMEOUT=16, pready_i=0 forever -> done_o with rsp_err_o=1
//     after 16 ACCESS cycles; FSM returns to IDLE.

Source files
------------

// File: rtl/gpio_apb_arbiter.sv
// rtl/gpio_apb_arbiter.sv - round-robin arbiter sharing the GPIO APB slave port; optional access timeout via GPIO_ARB_TIMEOUT_EN
module gpio_apb_arbiter #(
  parameter int NREQ       = 2,
  parameter int PADDR_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                       pclk,
  input  logic                       prstn,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*PADDR_SIZE-1:0] req_addr_i,
  input  logic [NREQ-1:0]            req_write_i,
  input  logic [NREQ*DATA_W-1:0]     req_wdata_i,
  input  logic [NREQ*DATA_W/8-1:0]   req_strb_i,
  output logic [NREQ-1:0]            done_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [PADDR_SIZE-1:0]      paddr_o,
  output logic [DATA_W-1:0]          pwdata_o,
  output logic [DATA_W/8-1:0]        pstrb_o,
  input  logic [DATA_W-1:0]          prdata_i,
  input  logic                       pready_i,
  input  logic                       pslverr_i
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || (DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gpio_apb_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, winner_q, pick_idx;
  logic                  pick_valid, pick_write;
  logic [PADDR_SIZE-1:0] pick_addr;
  logic [DATA_W-1:0]     pick_wdata;
  logic [STRB_W-1:0]     pick_strb;
  logic                  xfer_end, timeout_hit;

  // Round-robin pick: lowest requester at or above the pointer, else lowest below it
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_strb  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && IDX_W'(i) < rr_ptr_q) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && IDX_W'(i) >= rr_ptr_q) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_write = req_write_i[i];
        pick_addr  = req_addr_i[i*PADDR_SIZE +: PADDR_SIZE];
        pick_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        pick_strb  = req_strb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  // Next state and APB phase controls; completion happens only in ACCESS
  always_comb begin
    state_d   = state_q;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    xfer_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = SETUP;
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout_hit) begin
          xfer_end = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, winner, round-robin pointer and the APB request fields latched from the winner in IDLE
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        winner_q <= pick_idx;
        pwrite_o <= pick_write;
        paddr_o  <= pick_addr;
        pwdata_o <= pick_wdata;
        pstrb_o  <= pick_strb;
      end
      if (xfer_end) begin
        rr_ptr_q <= (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
      end
    end
  end

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] acc_cnt_q;

  // ACCESS-cycle counter, restarted in SETUP so every transfer gets the full budget
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      acc_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      acc_cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ACCESS) && !pready_i && (acc_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // One-hot completion strobe to the winner; read data passes straight through
  always_comb begin
    done_o = '0;
    if (xfer_end) done_o[winner_q] = 1'b1;
  end

  assign rsp_rdata_o = prdata_i;
  assign rsp_err_o   = timeout_hit | (pready_i & pslverr_i);

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb/tb_gpio_apb_arbiter.sv - self-checking bench for gpio_apb_arbiter
`timescale 1ns/1ps
module tb_gpio_apb_arbiter;
  localparam int NREQ = 2;
  localparam int PA   = 4;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TOUT = 16;

  logic              pclk = 1'b0;
  logic              prstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*PA-1:0] req_addr;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*SW-1:0] req_strb;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel, penable, pwrite;
  logic [PA-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [DW-1:0]     prdata;
  logic              pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  gpio_apb_arbiter #(.NREQ(NREQ), .PADDR_SIZE(PA), .DATA_W(DW), .TIMEOUT(TOUT)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_i(req), .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .done_o(done), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one outstanding transfer, its age in cycles since the grant edge
  bit             m_active;
  int             m_age, m_grantee, m_next;
  logic           m_write;
  logic [PA-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic [SW-1:0]  m_strb;

  function automatic void model_reset();
    m_active = 0; m_age = 0; m_grantee = 0; m_next = 0;
    m_write = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0;
  endfunction

  function automatic bit model_ends();
    bit expired = 0;
`ifdef GPIO_ARB_TIMEOUT_EN
    expired = (m_age >= TOUT + 1);
`endif
    return m_active && m_age >= 2 && (pready === 1'b1 || expired);
  endfunction

  function automatic void model_step();
    if (m_active) begin
      if (model_ends()) begin
        m_active = 0;
        m_next   = (m_grantee + 1) % NREQ;
      end else begin
        m_age++;
      end
    end else begin
      for (int d = 0; d < NREQ; d++) begin
        int i;
        i = (m_next + d) % NREQ;
        if (req[i]) begin
          m_active = 1; m_age = 1; m_grantee = i;
          m_write = req_write[i];
          m_addr  = req_addr[i*PA +: PA];
          m_wdata = req_wdata[i*DW +: DW];
          m_strb  = req_strb[i*SW +: SW];
          break;
        end
      end
    end
  endfunction

  // Compare process: every falling edge, DUT outputs against the model, then advance the model
  initial begin
    model_reset();
    forever begin
      @(negedge pclk);
      if (!prstn) begin
        model_reset();
        chk("m_rst_psel", psel, 0);
        chk("m_rst_penable", penable, 0);
        chk("m_rst_done", done, 0);
        chk("m_rst_paddr", paddr, 0);
      end else begin
        logic [NREQ-1:0] exp_done;
        exp_done = '0;
        if (model_ends()) exp_done[m_grantee] = 1'b1;
        chk("m_psel", psel, m_active);
        chk("m_penable", penable, m_active && m_age >= 2);
        chk("m_pwrite", pwrite, m_write);
        chk("m_paddr", paddr, m_addr);
        chk("m_pwdata", pwdata, m_wdata);
        chk("m_pstrb", pstrb, m_strb);
        chk("m_done", done, exp_done);
        if (exp_done != '0) begin
          chk("m_err", rsp_err, (pready === 1'b1) ? pslverr : 1'b1);
          if (!m_write) chk("m_rdata", rsp_rdata, prdata);
        end
        model_step();
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [PA-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i] = w;
    req_addr[i*PA +: PA] = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
  endtask

  task automatic wait_done(input string name, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge pclk);
      if (done !== '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done_o within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_access(input string name, input int budget);
    bit seen = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge pclk);
      if (penable === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ACCESS not reached within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dc, pulses;
    req = '0; req_addr = '0; req_write = '0; req_wdata = '0; req_strb = '0;
    prdata = 32'hA5A5_0001; pready = 1'b1; pslverr = 1'b0;
    prstn = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    @(posedge pclk); #1 prstn = 1'b1;
    @(posedge pclk); #1;

    // Both requesters held from reset: grants alternate 0,1,0,1 every 3 cycles
    set_req(0, 1'b0, 4'h2, 32'h0, 4'h0);
    set_req(1, 1'b1, 4'h5, 32'h0000_BEEF, 4'h3);
    req = 2'b11;
    k = cyc;
    for (int n = 0; n < 4; n++) begin
      wait_done("t2_done", 10, dc);
      chk("t2_idx", done, (n % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_cyc", dc, k + 2 + 3 * n);
      chk("t2_pwrite", pwrite, n % 2);
    end
    @(posedge pclk); #1 req = '0;
    @(posedge pclk); #1;

    // Single write from requester 0 with the k, k+1, k+2 phase timing
    set_req(0, 1'b1, 4'h1, 32'h0000_00FF, 4'hF);
    req = 2'b01;
    k = cyc;
    @(negedge pclk);
    chk("t1_idle_psel", psel, 0);
    @(negedge pclk);
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    wait_done("t1_done", 5, dc);
    chk("t1_cyc", dc, k + 2);
    chk("t1_idx", done, 2'b01);
    chk("t1_pwdata", pwdata, 32'h0000_00FF);
    chk("t1_paddr", paddr, 4'h1);
    chk("t1_err", rsp_err, 0);
    @(posedge pclk); #1 req = '0;
    @(posedge pclk); #1;

    // Read from requester 1; address change after the grant must not reach the bus
    set_req(1, 1'b0, 4'h3, 32'h0, 4'h0);
    req = 2'b10;
    @(posedge pclk); #1 set_req(1, 1'b0, 4'hE, 32'h0, 4'h0);
    wait_done("t3_done", 5, dc);
    chk("t3_idx", done, 2'b10);
    chk("t3_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("t3_paddr", paddr, 4'h3);
    @(posedge pclk); #1 req = '0;
    @(posedge pclk); #1;

    // Wait states: 5 ACCESS cycles with pready low, then a single error completion
    set_req(0, 1'b1, 4'h7, 32'h1234_5678, 4'h5);
    pready = 1'b0;
    req = 2'b01;
    wait_access("t4_access", 6);
    for (int n = 0; n < 4; n++) begin
      @(negedge pclk);
      chk("t4_hold_paddr", paddr, 4'h7);
      chk("t4_hold_done", done, 0);
    end
    @(posedge pclk); #1 pready = 1'b1; pslverr = 1'b1;
    wait_done("t4_done", 3, dc);
    chk("t4_idx", done, 2'b01);
    chk("t4_err", rsp_err, 1);
    chk("t4_pwdata", pwdata, 32'h1234_5678);
    @(posedge pclk); #1 req = '0; pslverr = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge pclk);
      if (done !== '0) pulses++;
    end
    chk("t4_extra_pulses", pulses, 0);

    // Reset during ACCESS aborts silently; requester 0 wins first afterwards
    set_req(0, 1'b0, 4'h4, 32'h0, 4'h0);
    set_req(1, 1'b1, 4'h6, 32'h0000_0066, 4'h1);
    pready = 1'b0;
    @(posedge pclk); #1 req = 2'b11;
    wait_access("t5_access", 6);
    chk("t5_pre_paddr", paddr, 4'h6);
    @(posedge pclk); #1 prstn = 1'b0;
    @(negedge pclk);
    chk("t5_psel", psel, 0);
    chk("t5_penable", penable, 0);
    chk("t5_paddr", paddr, 0);
    chk("t5_pwdata", pwdata, 0);
    chk("t5_done", done, 0);
    pready = 1'b1;
    @(posedge pclk); #1 prstn = 1'b1;
    k = cyc;
    wait_done("t5_done_after", 5, dc);
    chk("t5_first_idx", done, 2'b01);
    chk("t5_cyc", dc, k + 2);
    @(posedge pclk); #1 req = '0;
    @(posedge pclk); #1;

`ifdef GPIO_ARB_TIMEOUT_EN
    // Slave never ready: error completion in the 16th ACCESS cycle, late pready ignored
    set_req(0, 1'b0, 4'h9, 32'h0, 4'h0);
    pready = 1'b0;
    req = 2'b01;
    k = cyc;
    wait_done("t6_done", 40, dc);
    chk("t6_cyc", dc, k + 1 + TOUT);
    chk("t6_idx", done, 2'b01);
    chk("t6_err", rsp_err, 1);
    @(posedge pclk); #1 req = '0; pready = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge pclk);
      if (done !== '0) pulses++;
    end
    chk("t6_late_pulses", pulses, 0);
    chk("t6_idle_psel", psel, 0);
`endif

    repeat (2) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
